// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues 64-bit fetches, buffers {pc, inst} pairs for decode.
// Optional perf counters (perf_fetch_cnt, perf_stall_cnt) are enabled by defining FETCH_PERF_EN.
module inst_fetch_unit #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INST_NUM    = 2,
  parameter int                    FETCH_WIDTH = 32*INST_NUM,
  parameter int                    BUF_DEPTH   = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   CLK,
  input  logic                   RST,
  output logic [ADDR_WIDTH-1:0]  req_addr,
  output logic                   req_valid,
  input  logic [FETCH_WIDTH-1:0] resp_data,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_inst,
  output logic [ADDR_WIDTH-1:0]  out_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]            perf_fetch_cnt,
  output logic [31:0]            perf_stall_cnt
`endif
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_pc_req_p1;
  logic                  r_vld_p1;
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;
  logic [31:0]           r_buf_inst [BUF_DEPTH];
  logic [ADDR_WIDTH-1:0] r_buf_pc   [BUF_DEPTH];

  logic [31:0]           w_need;
  logic                  w_issue;
  logic                  w_enq;
  logic                  w_deq;
  logic                  w_nonempty;

  // Space check counts the in-flight pair but never credits a same-cycle dequeue.
  always_comb begin
    w_need     = 32'(r_count) + (r_vld_p1 ? 32'd2 : 32'd0) + 32'd2;
    w_nonempty = (r_count != '0);
    w_issue    = !RST && !redirect_valid && (w_need <= 32'(BUF_DEPTH));
    w_enq      = !RST && !redirect_valid && r_vld_p1;
    w_deq      = !RST && !redirect_valid && w_nonempty && out_ready;
  end

  assign req_valid = w_issue;
  assign req_addr  = r_pc & ALIGN_MASK;
  assign out_valid = !RST && !redirect_valid && w_nonempty;
  assign out_inst  = (!RST && w_nonempty) ? r_buf_inst[r_head] : '0;
  assign out_pc    = (!RST && w_nonempty) ? r_buf_pc[r_head]   : '0;

  // p0 -> p1: request issue; p1 -> buffer: response capture
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pc     <= RESET_PC & ALIGN_MASK;
      r_vld_p1 <= 1'b0;
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      r_pc     <= redirect_pc & ALIGN_MASK;
      r_vld_p1 <= 1'b0;
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
    end else begin
      r_vld_p1 <= w_issue;
      if (w_issue) r_pc <= r_pc + ADDR_WIDTH'(8);
      if (w_enq)   r_tail <= r_tail + PTR_W'(2);
      if (w_deq)   r_head <= r_head + PTR_W'(1);
      r_count <= r_count + (w_enq ? CNT_W'(2) : CNT_W'(0)) - (w_deq ? CNT_W'(1) : CNT_W'(0));
    end
  end

  always_ff @(posedge CLK) begin
    if (w_issue) r_pc_req_p1 <= r_pc & ALIGN_MASK;
    if (w_enq) begin
      r_buf_inst[r_tail]              <= resp_data[31:0];
      r_buf_pc[r_tail]                <= r_pc_req_p1;
      r_buf_inst[r_tail + PTR_W'(1)]  <= resp_data[63:32];
      r_buf_pc[r_tail + PTR_W'(1)]    <= r_pc_req_p1 + ADDR_WIDTH'(4);
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (req_valid)  perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (!out_valid) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a 1-cycle memory where word i holds i+0x100.
module tb_inst_fetch_unit;
  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] req_addr;
  logic        req_valid;
  logic [63:0] resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int errs   = 0;
  int checks = 0;

  inst_fetch_unit dut (
    .CLK            (CLK),
    .RST            (RST),
    .req_addr       (req_addr),
    .req_valid      (req_valid),
    .resp_data      (resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) + 32'h100;
  endfunction

  // Memory: data for the address requested this cycle appears next cycle; junk otherwise.
  always @(posedge CLK)
    resp_data <= req_valid ? {mem_word(req_addr + 32'd4), mem_word(req_addr)}
                           : 64'hDEAD_BEEF_DEAD_BEEF;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    step();
    #1;
    chk("rst_req_valid", req_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_inst",  out_inst,  0);
    chk("rst_out_pc",    out_pc,    0);
    chk("rst_req_addr",  req_addr,  0);
    step();
    RST = 1'b0;
  endtask

  logic exp_rv;

  initial begin
    RST = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;

    // Streaming with decode always ready
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      exp_rv = (c < 2) || (c >= 4 && c % 2 == 0);
      chk($sformatf("t1_rv_c%0d", c), req_valid, exp_rv);
      if (exp_rv) chk($sformatf("t1_addr_c%0d", c), req_addr, (c == 1) ? 8 : 8 * (c / 2));
      chk($sformatf("t1_ov_c%0d", c), out_valid, c >= 2);
      if (c >= 2) begin
        chk($sformatf("t1_pc_c%0d", c),   out_pc,   4 * (c - 2));
        chk($sformatf("t1_inst_c%0d", c), out_inst, 32'h100 + c - 2);
      end
      step();
    end

    // Decode stalled: buffer fills with two fetches, then drains in order
    do_reset();
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("t2_rv_c%0d", c), req_valid, c < 2);
      if (c < 2) chk($sformatf("t2_addr_c%0d", c), req_addr, 8 * c);
      chk($sformatf("t2_ov_c%0d", c), out_valid, c >= 2);
      if (c >= 2) begin
        chk($sformatf("t2_pc_c%0d", c),   out_pc,   0);
        chk($sformatf("t2_inst_c%0d", c), out_inst, 32'h100);
      end
      step();
    end
`ifdef FETCH_PERF_EN
    chk("t2_perf_fetch", perf_fetch_cnt, 2);
    chk("t2_perf_stall", perf_stall_cnt, 2);
`endif
    out_ready = 1'b1;
    for (int c = 10; c < 16; c++) begin
      #1;
      exp_rv = (c == 12) || (c == 14);
      chk($sformatf("t2_rv_c%0d", c), req_valid, exp_rv);
      if (exp_rv) chk($sformatf("t2_addr_c%0d", c), req_addr, (c == 12) ? 32'h10 : 32'h18);
      chk($sformatf("t2_ov_c%0d", c),   out_valid, 1);
      chk($sformatf("t2_pc_c%0d", c),   out_pc,    4 * (c - 10));
      chk($sformatf("t2_inst_c%0d", c), out_inst,  32'h100 + c - 10);
      step();
    end

    // Redirect while the 0x8 response is arriving, then back-to-back redirects
    do_reset();
    out_ready = 1'b1;
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1;
    chk("t3_rv_redir", req_valid, 0);
    chk("t3_ov_redir", out_valid, 0);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("t3_rv_c3",   req_valid, 1);
    chk("t3_addr_c3", req_addr,  32'h40);
    chk("t3_ov_c3",   out_valid, 0);
    step();
    #1;
    chk("t3_addr_c4", req_addr,  32'h48);
    chk("t3_ov_c4",   out_valid, 0);
    step();
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("t3_ov_k%0d", k),   out_valid, 1);
      chk($sformatf("t3_pc_k%0d", k),   out_pc,    32'h40 + 4 * k);
      chk($sformatf("t3_inst_k%0d", k), out_inst,  32'h110 + k);
      step();
    end
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    #1;
    chk("t4_rv_r1", req_valid, 0);
    chk("t4_ov_r1", out_valid, 0);
    step();
    redirect_pc = 32'h47;
    #1;
    chk("t4_rv_r2", req_valid, 0);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("t4_rv_a",   req_valid, 1);
    chk("t4_addr_a", req_addr,  32'h44);
    chk("t4_ov_a",   out_valid, 0);
    step();
    #1;
    chk("t4_addr_b", req_addr,  32'h4C);
    chk("t4_ov_b",   out_valid, 0);
    step();
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("t4_ov_k%0d", k),   out_valid, 1);
      chk($sformatf("t4_pc_k%0d", k),   out_pc,    32'h44 + 4 * k);
      chk($sformatf("t4_inst_k%0d", k), out_inst,  32'h111 + k);
      step();
    end

    // Reset mid-stream with three entries buffered
    do_reset();
    out_ready = 1'b1;
    step(); step(); step();
    #1;
    chk("t5_ov_pre",   out_valid, 1);
    chk("t5_pc_pre",   out_pc,    32'h4);
    chk("t5_addr_pre", req_addr,  32'h10);
    RST = 1'b1;
    #1;
    chk("t5_ov_rst",   out_valid, 0);
    chk("t5_inst_rst", out_inst,  0);
    chk("t5_rv_rst",   req_valid, 0);
    step();
    #1;
    chk("t5_addr_rst", req_addr,  32'h0);
    chk("t5_ov_rst2",  out_valid, 0);
    chk("t5_pc_rst2",  out_pc,    0);
    RST = 1'b0;
    #1;
    chk("t5_rv_c0",   req_valid, 1);
    chk("t5_addr_c0", req_addr,  32'h0);
    step();
    #1;
    chk("t5_addr_c1", req_addr,  32'h8);
    chk("t5_ov_c1",   out_valid, 0);
    step();
    #1;
    chk("t5_ov_c2",   out_valid, 1);
    chk("t5_pc_c2",   out_pc,    32'h0);
    chk("t5_inst_c2", out_inst,  32'h100);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
